req_ack_arbiter: RTL and testbench

Shares one burst engine among `N_REQ` requesters that drive level-held, four-phase req/ack handshakes, such as CPUs or slow interfaces that may miss clock cycles. Each requester raises `req` with a command held stable on its bus. The arbiter detects the request edge, grants the engine round-robin, and issues a single-cycle start pulse. When the engine reports done, it raises `ack` and holds it until the requester drops `req`. The block sits between the requester-side req/ack edge logic and the misaligned-address burst engine.

---
 rtl/req_arb_pkg.sv | 15 +
 rtl/req_arb_rr_pick.sv | 45 ++++
 rtl/req_ack_arbiter.sv | 136 +++++++++++++
 tb/tb_req_ack_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_arb_pkg.sv
// Shared types and helpers for the req/ack burst-engine arbiter.
package req_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } req_arb_state_e;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/req_arb_rr_pick.sv
// Combinational winner select over the pending vector: round-robin from rr_ptr_i,
// or lowest-index-wins when REQ_ARB_FIXED_PRIO_EN is defined (rr_ptr_i then unused).
module req_arb_rr_pick
    import req_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] pend_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] winner_o
);

`ifndef REQ_ARB_FIXED_PRIO_EN
    logic [IDX_W:0] sum;
`endif

    // Loops run from the far end so the highest-priority candidate is written last.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
`ifdef REQ_ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pend_i[i]) begin
                valid_o  = 1'b1;
                winner_o = IDX_W'(i);
            end
        end
`else
        sum = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            if (pend_i[sum[IDX_W-1:0]]) begin
                valid_o  = 1'b1;
                winner_o = sum[IDX_W-1:0];
            end
        end
`endif
    end

endmodule

// File: rtl/req_ack_arbiter.sv
// Arbitrates four-phase req/ack requesters onto one burst engine; grant one cycle after pend, start pulse the next.
// One burst outstanding; ack held until req drops. REQ_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
module req_ack_arbiter
    import req_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        req_en_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*LEN_W-1:0]  req_len_i,
    input  logic [N_REQ-1:0]        req_wr_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic                    eng_start_o,
    output logic [ADDR_W-1:0]       eng_addr_o,
    output logic [LEN_W-1:0]        eng_len_o,
    output logic                    eng_wr_o,
    input  logic                    eng_done_i,
    output logic [IDX_W-1:0]        grant_id_o,
    output logic                    busy_o
);

    req_arb_state_e    state_q, state_d;
    logic [N_REQ-1:0]  r, r_q;
    logic [N_REQ-1:0]  pend_q, pend_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  grant_vec, done_vec, active_vec;
    logic [ADDR_W-1:0] eng_addr_q, eng_addr_d;
    logic [LEN_W-1:0]  eng_len_q, eng_len_d;
    logic              eng_wr_q, eng_wr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_ptr;
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;

`ifndef REQ_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    assign r = req_i & req_en_i;

    req_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .pend_i   (pend_q),
        .rr_ptr_i (rr_ptr),
        .valid_o  (pick_vld),
        .winner_o (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        eng_addr_d = eng_addr_q;
        eng_len_d  = eng_len_q;
        eng_wr_d   = eng_wr_q;
        grant_d    = grant_q;
        grant_vec  = '0;
        done_vec   = '0;
        active_vec = '0;
`ifndef REQ_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    eng_addr_d          = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
                    eng_len_d           = req_len_i[int'(pick_idx)*LEN_W +: LEN_W];
                    eng_wr_d            = req_wr_i[pick_idx];
                    grant_d             = pick_idx;
                    grant_vec[pick_idx] = 1'b1;
                    state_d             = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (eng_done_i) begin
                    done_vec[grant_q] = r[grant_q];
`ifndef REQ_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            active_vec[grant_q] = 1'b1;
        end
        // A withdrawn request (r low) drops both its pending flag and its ack.
        pend_d = r & ((pend_q & ~grant_vec) | (~r_q & ~ack_q & ~active_vec));
        ack_d  = r & (ack_q | done_vec);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            r_q        <= '0;
            pend_q     <= '0;
            ack_q      <= '0;
            eng_addr_q <= '0;
            eng_len_q  <= '0;
            eng_wr_q   <= 1'b0;
            grant_q    <= '0;
`ifndef REQ_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            r_q        <= r;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            eng_addr_q <= eng_addr_d;
            eng_len_q  <= eng_len_d;
            eng_wr_q   <= eng_wr_d;
            grant_q    <= grant_d;
`ifndef REQ_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign ack_o       = ack_q;
    assign eng_start_o = (state_q == ISSUE);
    assign eng_addr_o  = eng_addr_q;
    assign eng_len_o   = eng_len_q;
    assign eng_wr_o    = eng_wr_q;
    assign grant_id_o  = grant_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Bench for req_ack_arbiter: directed scenarios plus a randomized run against an arbitration model.
module tb_req_ack_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, req_en, req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic          eng_done;
    logic [N-1:0]  ack;
    logic          eng_start;
    logic [AW-1:0] eng_addr;
    logic [LW-1:0] eng_len;
    logic          eng_wr;
    logic [1:0]    grant_id;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    req_ack_arbiter #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_en_i(req_en),
        .req_addr_i(req_addr), .req_len_i(req_len), .req_wr_i(req_wr),
        .ack_o(ack), .eng_start_o(eng_start), .eng_addr_o(eng_addr),
        .eng_len_o(eng_len), .eng_wr_o(eng_wr), .eng_done_i(eng_done),
        .grant_id_o(grant_id), .busy_o(busy)
    );

    // Reference model: phase 0 = engine free, 1 = start cycle, 2 = burst running.
    bit [N-1:0]    m_pend, m_ack, m_prev;
    int            m_phase, m_gid, m_last;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    logic          m_wr;

    function automatic int choose(input bit [N-1:0] p, input int last);
`ifdef REQ_ARB_FIXED_PRIO_EN
        for (int c = 0; c < N; c++) if (p[c]) return c;
`else
        for (int k = 1; k <= N; k++) if (p[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    always @(posedge clk) begin : model
        bit [N-1:0] rr, np, na;
        int w, old_phase, old_gid;
        rr = req & req_en;
        if (rst) begin
            m_pend = '0; m_ack = '0; m_prev = '0;
            m_phase = 0; m_gid = 0; m_last = N - 1;
            m_addr = '0; m_len = '0; m_wr = 1'b0;
        end else begin
            old_phase = m_phase;
            old_gid   = m_gid;
            np = m_pend;
            na = m_ack & rr;
            w  = -1;
            if (old_phase == 0) begin
                w = choose(m_pend, m_last);
                if (w >= 0) begin
                    m_addr = req_addr[w*AW +: AW];
                    m_len  = req_len[w*LW +: LW];
                    m_wr   = req_wr[w];
                    m_gid  = w;
                    m_phase = 1;
                end
            end else if (old_phase == 1) begin
                m_phase = 2;
            end else if (eng_done) begin
                if (rr[old_gid]) na[old_gid] = 1'b1;
                m_last  = old_gid;
                m_phase = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (!rr[i] || i == w) np[i] = 1'b0;
                else if (!m_prev[i] && !m_ack[i] && !(old_phase != 0 && i == old_gid)) np[i] = 1'b1;
            end
            m_pend = np;
            m_ack  = na;
            m_prev = rr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]  = l;
        req_wr[i]            = w;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_en = '1; eng_done = 1'b0;
        req_addr = '0; req_len = '0; req_wr = '0;
        step(); step();
        rst = 1'b0;
        checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %h expected 0", ack); end
        checks++; if ({eng_start, busy} !== 2'b00) begin errors++; $display("FAIL reset_start_busy: got %b expected 00", {eng_start, busy}); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        checks++; if ({eng_addr, eng_len, eng_wr} !== 41'd0) begin errors++; $display("FAIL reset_cmd: got %h/%h/%b expected 0", eng_addr, eng_len, eng_wr); end
    endtask

    task automatic test_single();
        set_cmd(1, 32'h1003, 8'd4, 1'b1);
        req[1] = 1'b1;
        step();
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b expected 0", eng_start); end
        step();
        checks++; if (eng_start !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL single_start: got start=%b grant=%0d expected 1/1", eng_start, grant_id); end
        checks++; if ({eng_addr, eng_len, eng_wr} !== {32'h1003, 8'd4, 1'b1}) begin errors++; $display("FAIL single_cmd: got %h/%h/%b expected 1003/04/1", eng_addr, eng_len, eng_wr); end
        step();
        checks++; if ({eng_start, busy} !== 2'b01) begin errors++; $display("FAIL single_wait: got start,busy=%b expected 01", {eng_start, busy}); end
        step(); step(); step();
        checks++; if (ack !== 4'h0) begin errors++; $display("FAIL single_ack_early: got %h expected 0", ack); end
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checks++; if (ack !== 4'b0010 || busy !== 1'b0) begin errors++; $display("FAIL single_ack: got ack=%h busy=%b expected 2/0", ack, busy); end
        step();
        checks++; if ({ack, eng_start} !== 5'b00100) begin errors++; $display("FAIL single_ack_hold: got %b expected 00100", {ack, eng_start}); end
        req[1] = 1'b0;
        step();
        checks++; if (ack !== 4'h0) begin errors++; $display("FAIL single_ack_release: got %h expected 0", ack); end
        step();
    endtask

    task automatic test_round_robin();
        int exp_order[4];
        bit found;
`ifdef REQ_ARB_FIXED_PRIO_EN
        exp_order = '{0, 2, 0, 3};
`else
        exp_order = '{0, 2, 3, 0};
`endif
        rst = 1'b1; req = '0; step(); rst = 1'b0;
        for (int i = 0; i < N; i++) set_cmd(i, 32'h4000 + 32'(i * 16), 8'(i + 1), i[0]);
        req = 4'b1101;
        for (int b = 0; b < 4; b++) begin
            found = 1'b0;
            for (int t = 0; t < 20; t++) begin
                step();
                if (eng_start === 1'b1) begin found = 1'b1; break; end
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL rr_timeout: burst %0d start seen=0 expected 1", b);
                req = '0; step(); return;
            end
            if (grant_id !== 2'(exp_order[b]) || eng_addr !== 32'h4000 + 32'(exp_order[b] * 16)) begin
                errors++; $display("FAIL rr_order: burst %0d got grant=%0d addr=%h expected %0d", b, grant_id, eng_addr, exp_order[b]);
            end
            if (b == 1) begin
                req[0] = 1'b0; step(); req[0] = 1'b1; step();
            end else begin
                step(); step();
            end
            eng_done = 1'b1; step(); eng_done = 1'b0;
        end
        checks++; if (ack !== 4'b1101) begin errors++; $display("FAIL rr_acks: got %b expected 1101", ack); end
        req = '0; step(); step();
    endtask

    task automatic test_withdraw();
        bit found, extra;
        set_cmd(1, 32'h1100, 8'd2, 1'b0);
        set_cmd(2, 32'h2200, 8'd3, 1'b1);
        req[1] = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (eng_start === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL withdraw_first_start: seen=0 expected 1"); end
        step();
        req[2] = 1'b1; step();
        req[2] = 1'b0; step();
        eng_done = 1'b1; step(); eng_done = 1'b0;
        req[1] = 1'b0;
        extra = 1'b0;
        for (int t = 0; t < 6; t++) begin
            step();
            if (eng_start !== 1'b0 || ack[2] !== 1'b0) extra = 1'b1;
        end
        checks++; if (extra) begin errors++; $display("FAIL withdraw_no_grant: got start/ack activity=1 expected 0"); end
    endtask

    task automatic test_drop_in_wait();
        bit found;
        set_cmd(1, 32'h1500, 8'd7, 1'b1);
        set_cmd(3, 32'h3000, 8'd9, 1'b0);
        req[1] = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (eng_start === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL drop_start: seen=0 expected 1"); end
        step();
        req[1] = 1'b0; req[3] = 1'b1;
        step(); step();
        eng_done = 1'b1; step(); eng_done = 1'b0;
        checks++; if (ack !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL drop_no_ack: got ack=%h busy=%b expected 0/0", ack, busy); end
        step();
        checks++; if (eng_start !== 1'b1 || grant_id !== 2'd3 || eng_addr !== 32'h3000) begin errors++; $display("FAIL drop_next_grant: got start=%b grant=%0d addr=%h expected 1/3/3000", eng_start, grant_id, eng_addr); end
        step();
        eng_done = 1'b1; step(); eng_done = 1'b0;
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL drop_next_ack: got %b expected 1000", ack); end
        req = '0; step();
    endtask

    task automatic test_req_en();
        bit extra;
        set_cmd(2, 32'h2abc, 8'd5, 1'b1);
        req_en = 4'b1011; req[2] = 1'b1;
        extra = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step();
            if (eng_start !== 1'b0 || busy !== 1'b0 || ack !== 4'h0) extra = 1'b1;
        end
        checks++; if (extra) begin errors++; $display("FAIL req_en_masked: got activity=1 expected 0"); end
        req_en[2] = 1'b1;
        step(); step();
        checks++; if (eng_start !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL req_en_grant: got start=%b grant=%0d expected 1/2", eng_start, grant_id); end
        step();
        eng_done = 1'b1; step(); eng_done = 1'b0;
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL req_en_ack: got %b expected 0100", ack); end
        req = '0; step();
    endtask

    task automatic test_reset_in_wait();
        bit found;
        set_cmd(0, 32'h0dd0, 8'd6, 1'b1);
        req[0] = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (eng_start === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rstw_start: seen=0 expected 1"); end
        step();
        rst = 1'b1; req = '0;
        step();
        checks++; if ({ack, eng_start, busy, grant_id} !== 8'h00) begin errors++; $display("FAIL rstw_state: got ack=%h start=%b busy=%b grant=%0d expected all 0", ack, eng_start, busy, grant_id); end
        checks++; if ({eng_addr, eng_len, eng_wr} !== 41'd0) begin errors++; $display("FAIL rstw_cmd: got %h/%h/%b expected 0", eng_addr, eng_len, eng_wr); end
        rst = 1'b0; eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        step();
        checks++; if ({ack, eng_start, busy} !== 6'd0) begin errors++; $display("FAIL rstw_stray_done: got %b expected 0", {ack, eng_start, busy}); end
    endtask

    task automatic test_random();
        int cnt;
        cnt = 0;
        rst = 1'b1; req = '0; req_en = '1; eng_done = 1'b0;
        step();
        rst = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            checks++; if (ack !== m_ack) begin errors++; $display("FAIL rand_ack @%0d: got %b expected %b", cyc, ack, m_ack); end
            checks++; if (eng_start !== (m_phase == 1) || busy !== (m_phase != 0)) begin errors++; $display("FAIL rand_start_busy @%0d: got %b%b expected phase %0d", cyc, eng_start, busy, m_phase); end
            checks++; if (grant_id !== 2'(m_gid)) begin errors++; $display("FAIL rand_grant @%0d: got %0d expected %0d", cyc, grant_id, m_gid); end
            checks++; if ({eng_addr, eng_len, eng_wr} !== {m_addr, m_len, m_wr}) begin errors++; $display("FAIL rand_cmd @%0d: got %h/%h/%b expected %h/%h/%b", cyc, eng_addr, eng_len, eng_wr, m_addr, m_len, m_wr); end
            eng_done = 1'b0;
            rst = 1'b0;
            if (eng_start === 1'b1) cnt = $urandom_range(1, 6);
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) eng_done = 1'b1;
            end
            if (m_phase != 2 && cnt == 0 && $urandom_range(0, 15) == 0) eng_done = 1'b1;
            if ($urandom_range(0, 299) == 0) begin rst = 1'b1; cnt = 0; end
            for (int i = 0; i < N; i++) begin
                if (req[i] == 1'b0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_cmd(i, $urandom, 8'($urandom), 1'($urandom));
                        req[i] = 1'b1;
                    end
                end else if (ack[i] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0)) begin
                    req[i] = 1'b0;
                end
                if (req_en[i] && $urandom_range(0, 31) == 0) req_en[i] = 1'b0;
                else if (!req_en[i] && $urandom_range(0, 3) == 0) req_en[i] = 1'b1;
            end
            step();
        end
        req = '0; eng_done = 1'b0; rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_drop_in_wait();
        test_req_en();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
